// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with a single-entry output register.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
//
// Parameters:
//   CLOCK_FREQ      clk frequency in Hz
//   BAUD_RATE       serial bit rate
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   serial_in       asynchronous UART line (idle high, LSB first)
//   data_out        received byte
//   data_out_valid  data_out holds an unconsumed byte
//   data_out_ready  consumer accepts data_out when valid & ready
//   framing_error   one-cycle pulse when the stop bit samples low
//   overrun         one-cycle pulse when a completed byte is dropped
module uart_receiver #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF             = SYMBOL_EDGE_TIME / 2;

`ifdef UART_RX_MAJORITY_EN
    // Decisions move one cycle later so the sample after mid-bit exists;
    // the counter must therefore reach SYMBOL_EDGE_TIME itself.
    localparam int CW  = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam int LAG = 1;
`else
    localparam int CW  = $clog2(SYMBOL_EDGE_TIME);
    localparam int LAG = 0;
`endif

    localparam logic [CW-1:0] HALF_C = CW'(HALF + LAG);
    localparam logic [CW-1:0] BIT_C  = CW'(SYMBOL_EDGE_TIME - 1 + LAG);
    // Restart value after a decision keeps the bit period exact when the
    // decision itself is delayed by LAG cycles.
    localparam logic [CW-1:0] RELOAD = CW'(LAG);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]    sync;
    logic          rx;
    logic          line;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          done;
    logic          fe_n;
    logic          ov_n;
    logic          valid_n;
    logic [7:0]    dout_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], serial_in};
    end

    assign rx = sync[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist <= 2'b11;
        else       hist <= {hist[0], rx};
    end

    // hist[1], hist[0], rx = samples at mid-bit-1, mid-bit, mid-bit+1
    assign line = (hist[1] & hist[0]) | (hist[1] & rx) | (hist[0] & rx);
`else
    assign line = rx;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        done    = 1'b0;
        fe_n    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx) state_n = START;
            end
            START: begin
                if (cnt == HALF_C) begin
                    if (!line) begin
                        state_n = DATA;
                        cnt_n   = RELOAD;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_C) begin
                    shreg_n[idx] = line;
                    cnt_n        = RELOAD;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_C) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    if (line) done = 1'b1;
                    else      fe_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output register: a completed byte replaces the held one only when
    // the slot is empty or is being consumed on this very cycle.
    always_comb begin
        valid_n = data_out_valid;
        dout_n  = data_out;
        ov_n    = 1'b0;
        if (data_out_valid && data_out_ready) valid_n = 1'b0;
        if (done) begin
            if (!data_out_valid || data_out_ready) begin
                dout_n  = shreg;
                valid_n = 1'b1;
            end else begin
                ov_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            idx            <= idx_n;
            shreg          <= shreg_n;
            data_out       <= dout_n;
            data_out_valid <= valid_n;
            framing_error  <= fe_n;
            overrun        <= ov_n;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver.
// Frames are generated bit by bit; expected events are queued per frame.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int CF   = 100_000_000;
    localparam int BR   = 400_000;
    localparam int SYM  = CF / BR;
    localparam int HALF = SYM / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = 2 + 9 * SYM + HALF + 1 + EXTRA;

    localparam int K_BYTE = 0;
    localparam int K_FE   = 1;
    localparam int K_OV   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       framing_error;
    logic       overrun;

    uart_receiver #(
        .CLOCK_FREQ(CF),
        .BAUD_RATE (BR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t0;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   model_full = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Reference: a bad stop bit yields a framing error; a good frame
    // lands in the slot if empty, otherwise it is reported as overrun.
    function automatic void expect_frame(input logic [7:0] b,
                                         input bit ok, input int t0);
        exp_t e;
        e.data = b;
        e.t0   = t0;
        if (!ok) begin
            e.kind = K_FE;
        end else if (model_full) begin
            e.kind = K_OV;
        end else begin
            e.kind = K_BYTE;
            model_full = 1;
        end
        q.push_back(e);
    endfunction

    // Called at #1 after a rising edge. glitch_c forces one low cycle;
    // abort_c pulses reset at that cycle and abandons the frame.
    task automatic send_frame(input logic [7:0] b, input logic [7:0] eb,
                              input bit ok, input int glitch_c,
                              input int abort_c);
        int   bn;
        logic v;
        if (abort_c < 0) expect_frame(eb, ok, cyc);
        for (int c = 0; c < 10 * SYM; c++) begin
            if (c == abort_c) begin
                reset      = 1'b1;
                serial_in  = 1'b1;
                model_full = 0;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_mid_data", data_out, 8'h00);
                chk("rst_mid_valid", data_out_valid, 1'b0);
                chk("rst_mid_fe", framing_error, 1'b0);
                chk("rst_mid_ov", overrun, 1'b0);
                reset = 1'b0;
                return;
            end
            bn = c / SYM;
            if (bn == 0)      v = 1'b0;
            else if (bn == 9) v = ok;
            else              v = b[bn-1];
            if (c == glitch_c) v = 1'b0;
            serial_in = v;
            @(posedge clk);
            #1;
        end
        serial_in = 1'b1;
    endtask

    task automatic consume();
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        chk("valid_clear", data_out_valid, 1'b0);
        model_full = 0;
    endtask

    // Monitor: every output event pops one expected entry.
    task automatic pop_chk(input int kind, input logic [7:0] d);
        exp_t e;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %0h want none",
                     kind, d);
            return;
        end
        e = q.pop_front();
        if (e.kind != kind || (kind == K_BYTE && e.data != d)) begin
            n_fail++;
            $display("FAIL event: got kind %0d data %0h want kind %0d data %0h",
                     kind, d, e.kind, e.data);
        end
        if (kind == K_BYTE && e.kind == K_BYTE) begin
            n_tests++;
            if (cyc - e.t0 < LAT - 2 || cyc - e.t0 > LAT + 2) begin
                n_fail++;
                $display("FAIL latency: got %0d want %0d +-2",
                         cyc - e.t0, LAT);
            end
        end
    endtask

    initial begin
        bit pv;
        bit phs;
        pv  = 0;
        phs = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (framing_error) pop_chk(K_FE, 8'h00);
                if (overrun) pop_chk(K_OV, 8'h00);
                if (data_out_valid && (!pv || phs)) pop_chk(K_BYTE, data_out);
            end
            pv  = data_out_valid;
            phs = data_out_valid && data_out_ready;
        end
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        int         w;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", data_out, 8'h00);
        chk("reset_valid", data_out_valid, 1'b0);
        chk("reset_fe", framing_error, 1'b0);
        chk("reset_ov", overrun, 1'b0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        send_frame(8'h41, 8'h41, 1, -1, -1);
        repeat (50) @(posedge clk);
        #1;
        chk("hold_valid", data_out_valid, 1'b1);
        chk("hold_data", data_out, 8'h41);
        consume();

        serial_in = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        serial_in = 1'b1;
        repeat (3 * SYM) @(posedge clk);
        #1;
        chk("glitch_valid", data_out_valid, 1'b0);

        send_frame(8'h55, 8'h55, 0, -1, -1);
        repeat (SYM) @(posedge clk);
        #1;
        chk("fe_valid", data_out_valid, 1'b0);
        chk("fe_drained", q.size(), 0);

        send_frame(8'h12, 8'h12, 1, -1, -1);
        send_frame(8'h34, 8'h34, 1, -1, -1);
        repeat (20) @(posedge clk);
        #1;
        chk("ovr_data", data_out, 8'h12);
        consume();

        send_frame(8'h99, 8'h99, 1, -1, 4 * SYM + SYM / 2);
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'hA5, 8'hA5, 1, -1, -1);
        repeat (20) @(posedge clk);
        #1;
        chk("after_rst_data", data_out, 8'hA5);
        consume();

        // One low cycle lands on the bit-0 mid sample: 3 cycles of start
        // detection, HALF+1 to mid start bit, one symbol to mid bit 0.
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'hFF, 8'hFF, 1, SYM + HALF + 1, -1);
`else
        send_frame(8'hFF, 8'hFE, 1, SYM + HALF + 1, -1);
`endif
        repeat (20) @(posedge clk);
        #1;
        consume();

        for (int i = 0; i < 8; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, b, ok, -1, -1);
            w = 20 + $urandom_range(0, 20);
            repeat (w) @(posedge clk);
            #1;
            if (model_full && $urandom_range(0, 1) == 1) consume();
        end
        if (model_full) consume();

        w = 0;
        while (q.size() != 0 && w < 3 * SYM) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100_000_000: clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200: serial bit rate.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port serial_in  input  1  asynchronous UART line; idle high, 8N1, LSB first.
REQ-006 SHALL have port data_out  output  8  received byte.
REQ-007 SHALL have port data_out_valid  output  1  data_out holds an unconsumed byte.
REQ-008 SHALL have port data_out_ready  input  1  consumer accepts data_out on the cycle where valid&ready is high.
REQ-009 SHALL have port framing_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-011 SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division; 868 at defaults) and HALF = SYMBOL_EDGE_TIME/2 (434).
REQ-012 SHALL pass serial_in through a 2-flop synchronizer; all decisions use the synchronized line.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, with a bit-time counter of width clog2(SYMBOL_EDGE_TIME) and a 3-bit bit index.
REQ-014 IDLE: synchronized line low -> START; counter cleared.
REQ-015 START: at counter==HALF, line low -> DATA with counter cleared; line high -> IDLE (glitch rejection, no outputs change).
REQ-016 DATA: sample at each counter==SYMBOL_EDGE_TIME-1 (mid-bit), shift into bit (index) LSB first; after bit 7 -> STOP.
REQ-017 STOP: sample at mid-bit; high -> byte complete; low -> framing_error pulse for 1 cycle, byte discarded; either case -> IDLE on the same edge.
REQ-018 Byte complete with data_out_valid low: data_out loaded, data_out_valid set on the next edge.
REQ-019 Byte complete with data_out_valid high and data_out_ready low: new byte dropped, data_out unchanged, overrun pulses for 1 cycle.
REQ-020 Byte complete in the same cycle as valid&ready: new byte loaded, data_out_valid stays 1, no overrun.
REQ-021 data_out_valid SHALL clear on the edge after valid&ready when no byte completes; data_out stays stable while valid is high.
REQ-022 Latency: data_out_valid rises 2 + 9*SYMBOL_EDGE_TIME + HALF + 1 cycles (8249 at defaults, bench tolerance ±2) after the serial_in start-bit falling edge.
REQ-023 Receiver SHALL return to IDLE after the stop-bit sample, so back-to-back frames with no idle gap are received.

Reset
REQ-024 On reset: state IDLE, counters 0, synchronizer flops 1, data_out 8'h00, data_out_valid 0, framing_error 0, overrun 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, reception restarts on the next falling edge.

Configuration
REQ-026 Macro UART_RX_MAJORITY_EN defined: each start, data and stop decision is the 2-of-3 majority of samples at mid-bit-1, mid-bit and mid-bit+1, decided at mid-bit+1 (latency +1 cycle).
REQ-027 Macro UART_RX_MAJORITY_EN undefined: single sample at mid-bit, no extra latency; no majority logic present.

Verification
REQ-028 Off-chip UART sends 0x41 at 115200, data_out_ready low -> data_out=0x41, valid high at about 8249 cycles and held; one-cycle ready -> valid drops next edge.
REQ-029 100-cycle low glitch on idle serial_in -> no valid, no framing_error, state back to IDLE.
REQ-030 Frame 0x55 with stop bit driven low -> framing_error pulses once, data_out_valid stays 0.
REQ-031 Frames 0x12 then 0x34 back-to-back, ready held low -> data_out=0x12, overrun pulses once at 0x34 stop bit.
REQ-032 Reset pulsed during bit 3 of 0x99, then 0xA5 sent -> outputs 0 after reset; data_out=0xA5 valid.
REQ-033 Frame 0xFF with a 1-cycle low glitch exactly at bit-0 mid-sample -> with UART_RX_MAJORITY_EN data_out=0xFF; without, data_out=0xFE.
